// File: rtl/regfile_arbiter.sv
// Shares the single register-file port between write-back, decode and debug,
// with starvation promotion for debug and a debug halt mode.
module regfile_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        wb_req,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_gnt,
   input  logic        id_req,
   input  logic [4:0]  id_addr_a,
   input  logic [4:0]  id_addr_b,
   output logic        id_gnt,
   output logic        id_rvalid,
   output logic [31:0] id_data_a,
   output logic [31:0] id_data_b,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [4:0]  dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   input  logic        dbg_halt,
   output logic        halted,
   output logic [4:0]  rf_read_addr_a,
   output logic [4:0]  rf_read_addr_b,
   output logic [4:0]  rf_write_address,
   output logic [31:0] rf_write_data,
   output logic        rf_reg_write,
   input  logic [31:0] rf_data_a,
   input  logic [31:0] rf_data_b
);
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_ID, OWN_DBG} owner_t;

   state_t           state, state_nxt;
   owner_t           rd_owner, rd_owner_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
   logic [AW-1:0]    addr_a_q, addr_b_q, waddr_q;
   logic [DW-1:0]    wdata_q;
   logic             pipe_ok;
   logic             dbg_starved;

   assign pipe_ok     = (state == RUN);
   assign dbg_starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // One grant per cycle; nothing is granted while reset is held.
   always_comb begin
      wb_gnt  = 1'b0;
      id_gnt  = 1'b0;
      dbg_gnt = 1'b0;
      if (reset_n) begin
         if (dbg_req && (dbg_starved || !pipe_ok)) dbg_gnt = 1'b1;
         else if (pipe_ok && wb_req)               wb_gnt  = 1'b1;
         else if (pipe_ok && id_req)               id_gnt  = 1'b1;
         else if (dbg_req)                         dbg_gnt = 1'b1;
      end
   end

   // Port drive; without a grant the previous addresses and data are held.
   always_comb begin
      rf_reg_write     = 1'b0;
      rf_write_address = waddr_q;
      rf_write_data    = wdata_q;
      rf_read_addr_a   = addr_a_q;
      rf_read_addr_b   = addr_b_q;
      if (wb_gnt) begin
         rf_reg_write     = 1'b1;
         rf_write_address = wb_addr;
         rf_write_data    = wb_data;
      end else if (dbg_gnt && dbg_we) begin
         rf_reg_write     = 1'b1;
         rf_write_address = dbg_addr;
         rf_write_data    = dbg_wdata;
      end else if (id_gnt) begin
         rf_read_addr_a = id_addr_a;
         rf_read_addr_b = id_addr_b;
      end else if (dbg_gnt) begin
         rf_read_addr_a = dbg_addr;
         rf_read_addr_b = dbg_addr;
      end
   end

   // Next-state for halt FSM, read owner and debug starvation counter.
   always_comb begin
      state_nxt      = state;
      rd_owner_nxt   = OWN_NONE;
      starve_cnt_nxt = starve_cnt;
      unique case (state)
         RUN:     if (dbg_halt) state_nxt = DRAIN;
         DRAIN:   if (!dbg_halt) state_nxt = RUN;
                  else if (rd_owner != OWN_ID) state_nxt = HALTED;
         HALTED:  if (!dbg_halt) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
      if (id_gnt)                  rd_owner_nxt = OWN_ID;
      else if (dbg_gnt && !dbg_we) rd_owner_nxt = OWN_DBG;
      if (!dbg_req || dbg_gnt)     starve_cnt_nxt = '0;
      else if (!dbg_starved)       starve_cnt_nxt = starve_cnt + CNT_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RUN;
         halted     <= 1'b0;
         rd_owner   <= OWN_NONE;
         starve_cnt <= '0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         state      <= state_nxt;
         halted     <= (state_nxt == HALTED);
         rd_owner   <= rd_owner_nxt;
         starve_cnt <= starve_cnt_nxt;
         addr_a_q   <= rf_read_addr_a;
         addr_b_q   <= rf_read_addr_b;
         waddr_q    <= rf_write_address;
         wdata_q    <= rf_write_data;
      end
   end

   assign id_rvalid  = (rd_owner == OWN_ID);
   assign dbg_rvalid = (rd_owner == OWN_DBG);
   assign id_data_a  = rf_data_a;
   assign id_data_b  = rf_data_b;
   assign dbg_rdata  = rf_data_a;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with a behavioural 32x32 register file and
// read-data scoreboards for the decode and debug ports.
module tb_regfile_arbiter;
   logic        clock = 1'b0;
   logic        reset_n;
   logic        wb_req, id_req, dbg_req, dbg_we, dbg_halt;
   logic [4:0]  wb_addr, id_addr_a, id_addr_b, dbg_addr;
   logic [31:0] wb_data, dbg_wdata;
   logic        wb_gnt, id_gnt, dbg_gnt, id_rvalid, dbg_rvalid, halted;
   logic [31:0] id_data_a, id_data_b, dbg_rdata;
   logic [4:0]  rf_read_addr_a, rf_read_addr_b, rf_write_address;
   logic [31:0] rf_write_data, rf_data_a, rf_data_b;
   logic        rf_reg_write;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [63:0] id_q[$];
   logic [31:0] dbg_q[$];

   regfile_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
      .id_req(id_req), .id_addr_a(id_addr_a), .id_addr_b(id_addr_b), .id_gnt(id_gnt),
      .id_rvalid(id_rvalid), .id_data_a(id_data_a), .id_data_b(id_data_b),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dbg_halt(dbg_halt), .halted(halted),
      .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
      .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
      .rf_reg_write(rf_reg_write), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
   );

   always #5 clock = ~clock;

   // Register file: r0=2, r1=3, rN=0x100+N until written; registered reads.
   logic [31:0] mem [32];
   logic [31:0] wr_mask = '0;

   function automatic logic [31:0] init_val(input logic [4:0] a);
      if (a == 5'd0) return 32'd2;
      if (a == 5'd1) return 32'd3;
      return 32'h100 + 32'(a);
   endfunction

   always @(posedge clock) begin
      if (rf_reg_write) begin
         mem[rf_write_address]     <= rf_write_data;
         wr_mask[rf_write_address] <= 1'b1;
      end
      rf_data_a <= wr_mask[rf_read_addr_a] ? mem[rf_read_addr_a] : init_val(rf_read_addr_a);
      rf_data_b <= wr_mask[rf_read_addr_b] ? mem[rf_read_addr_b] : init_val(rf_read_addr_b);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic clear_inputs();
      wb_req = 1'b0; wb_addr = '0; wb_data = '0;
      id_req = 1'b0; id_addr_a = '0; id_addr_b = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 1'b0;
   endtask

   task automatic test_reset();
      logic [63:0] e;
      reset_n = 1'b0;
      clear_inputs();
      step(); sample();
      tests_run++; if ({wb_gnt, id_gnt, dbg_gnt, id_rvalid, dbg_rvalid, halted, rf_reg_write} !== 7'b0) begin tests_failed++; $display("FAIL rst_ctrl: got %b want 0", {wb_gnt, id_gnt, dbg_gnt, id_rvalid, dbg_rvalid, halted, rf_reg_write}); end
      tests_run++; if ({rf_read_addr_a, rf_read_addr_b, rf_write_address, rf_write_data} !== 47'b0) begin tests_failed++; $display("FAIL rst_rf: got %h want 0", {rf_read_addr_a, rf_read_addr_b, rf_write_address, rf_write_data}); end
      step(); reset_n = 1'b1; id_req = 1'b1; id_addr_a = 5'd1; id_addr_b = 5'd0;
      sample();
      tests_run++; if (id_gnt !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_gnt: got %b want 1", id_gnt); end
      step(); id_req = 1'b0; reset_n = 1'b0;
      sample();
      tests_run++; if ({id_rvalid, dbg_rvalid, wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_read_addr_a} !== 11'b0) begin tests_failed++; $display("FAIL rst_mid_read: got %h want 0", {id_rvalid, dbg_rvalid, wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_read_addr_a}); end
      step(); reset_n = 1'b1;
      sample();
      tests_run++; if (id_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_dropped: got %b want 0", id_rvalid); end
      step(); id_req = 1'b1; id_addr_a = 5'd1; id_addr_b = 5'd0; id_q.push_back({32'd3, 32'd2});
      sample();
      tests_run++; if (id_gnt !== 1'b1) begin tests_failed++; $display("FAIL rst_first_gnt: got %b want 1", id_gnt); end
      step(); id_req = 1'b0;
      sample();
      tests_run++;
      if (id_rvalid !== 1'b1 || id_q.size() == 0) begin tests_failed++; $display("FAIL rst_rvalid: got %b want 1", id_rvalid); end
      else begin
         e = id_q.pop_front();
         if ({id_data_a, id_data_b} !== e) begin tests_failed++; $display("FAIL rst_data: got %h want %h", {id_data_a, id_data_b}, e); end
      end
   endtask

   task automatic test_write_read();
      logic [63:0] e;
      step();
      wb_req = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      id_req = 1'b1; id_addr_a = 5'd5; id_addr_b = 5'd1; id_q.push_back({32'hDEADBEEF, 32'd3});
      sample();
      tests_run++; if ({wb_gnt, id_gnt, dbg_gnt} !== 3'b100) begin tests_failed++; $display("FAIL wr_gnt: got %b want 100", {wb_gnt, id_gnt, dbg_gnt}); end
      tests_run++; if ({rf_reg_write, rf_write_address, rf_write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL wr_drive: got %h want %h", {rf_reg_write, rf_write_address, rf_write_data}, {1'b1, 5'd5, 32'hDEADBEEF}); end
      step(); wb_req = 1'b0;
      sample();
      tests_run++; if ({wb_gnt, id_gnt, rf_reg_write, rf_read_addr_a, rf_read_addr_b} !== {3'b010, 5'd5, 5'd1}) begin tests_failed++; $display("FAIL rd_gnt: got %h want %h", {wb_gnt, id_gnt, rf_reg_write, rf_read_addr_a, rf_read_addr_b}, {3'b010, 5'd5, 5'd1}); end
      step(); id_req = 1'b0;
      sample();
      tests_run++;
      if (id_rvalid !== 1'b1 || id_q.size() == 0) begin tests_failed++; $display("FAIL wr_rvalid: got %b want 1", id_rvalid); end
      else begin
         e = id_q.pop_front();
         if ({id_data_a, id_data_b} !== e) begin tests_failed++; $display("FAIL wr_rd_data: got %h want %h", {id_data_a, id_data_b}, e); end
      end
      tests_run++; if ({rf_read_addr_a, rf_read_addr_b, rf_reg_write} !== {5'd5, 5'd1, 1'b0}) begin tests_failed++; $display("FAIL addr_hold: got %h want %h", {rf_read_addr_a, rf_read_addr_b, rf_reg_write}, {5'd5, 5'd1, 1'b0}); end
   endtask

   task automatic test_starvation();
      int gnt1, gnt2;
      logic [31:0] e;
      gnt1 = 0; gnt2 = 0;
      step();
      wb_req = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000A5A5;
      id_req = 1'b1; id_addr_a = 5'd2; id_addr_b = 5'd3;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_q.push_back(32'd2);
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) step();
         sample();
         if (dbg_gnt === 1'b1) begin gnt1 = c; break; end
      end
      tests_run++; if (gnt1 != 5) begin tests_failed++; $display("FAIL starve_gnt_cycle: got %0d want 5", gnt1); end
      tests_run++; if ({wb_gnt, id_gnt, rf_reg_write, rf_read_addr_a, rf_read_addr_b} !== 13'b0) begin tests_failed++; $display("FAIL starve_drive: got %h want 0", {wb_gnt, id_gnt, rf_reg_write, rf_read_addr_a, rf_read_addr_b}); end
      step(); dbg_addr = 5'd1; dbg_q.push_back(32'd3);
      sample();
      tests_run++;
      if (dbg_rvalid !== 1'b1 || dbg_q.size() == 0) begin tests_failed++; $display("FAIL starve_rvalid: got %b want 1", dbg_rvalid); end
      else begin
         e = dbg_q.pop_front();
         if (dbg_rdata !== e) begin tests_failed++; $display("FAIL starve_data: got %h want %h", dbg_rdata, e); end
      end
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin step(); sample(); end
         if (dbg_gnt === 1'b1) begin gnt2 = c; break; end
      end
      tests_run++; if (gnt2 != 5) begin tests_failed++; $display("FAIL starve_cnt_clear: got %0d want 5", gnt2); end
      step(); clear_inputs();
      sample();
      tests_run++;
      if (dbg_rvalid !== 1'b1 || dbg_q.size() == 0) begin tests_failed++; $display("FAIL starve_rvalid2: got %b want 1", dbg_rvalid); end
      else begin
         e = dbg_q.pop_front();
         if (dbg_rdata !== e) begin tests_failed++; $display("FAIL starve_data2: got %h want %h", dbg_rdata, e); end
      end
   endtask

   task automatic test_halt();
      logic [63:0] e;
      logic [31:0] d;
      logic pipe_gnt_seen, halt_seen;
      pipe_gnt_seen = 1'b0; halt_seen = 1'b0;
      step(); id_req = 1'b1; id_addr_a = 5'd0; id_addr_b = 5'd1; id_q.push_back({32'd2, 32'd3});
      sample();
      tests_run++; if (id_gnt !== 1'b1) begin tests_failed++; $display("FAIL halt_pre_gnt: got %b want 1", id_gnt); end
      step(); id_req = 1'b0; dbg_halt = 1'b1;
      sample();
      tests_run++;
      if (id_rvalid !== 1'b1 || id_q.size() == 0) begin tests_failed++; $display("FAIL halt_rvalid: got %b want 1", id_rvalid); end
      else begin
         e = id_q.pop_front();
         if ({id_data_a, id_data_b} !== e) begin tests_failed++; $display("FAIL halt_rd_data: got %h want %h", {id_data_a, id_data_b}, e); end
      end
      step();
      wb_req = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
      id_req = 1'b1; id_addr_a = 5'd2; id_addr_b = 5'd2;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) step();
         sample();
         if (wb_gnt !== 1'b0 || id_gnt !== 1'b0) pipe_gnt_seen = 1'b1;
         if (halted === 1'b1) begin halt_seen = 1'b1; break; end
      end
      tests_run++; if (halt_seen !== 1'b1) begin tests_failed++; $display("FAIL halt_reached: got %b want 1", halt_seen); end
      tests_run++; if (pipe_gnt_seen !== 1'b0) begin tests_failed++; $display("FAIL drain_pipe_gnt: got %b want 0", pipe_gnt_seen); end
      step(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h12;
      sample();
      tests_run++; if ({wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_write_address, rf_write_data} !== {4'b0011, 5'd7, 32'h12}) begin tests_failed++; $display("FAIL halt_dbg_wr: got %h want %h", {wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_write_address, rf_write_data}, {4'b0011, 5'd7, 32'h12}); end
      step(); dbg_we = 1'b0; dbg_q.push_back(32'h12);
      sample();
      tests_run++; if ({wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_read_addr_a, halted} !== {4'b0010, 5'd7, 1'b1}) begin tests_failed++; $display("FAIL halt_dbg_rd: got %h want %h", {wb_gnt, id_gnt, dbg_gnt, rf_reg_write, rf_read_addr_a, halted}, {4'b0010, 5'd7, 1'b1}); end
      step(); dbg_req = 1'b0; dbg_halt = 1'b0;
      sample();
      tests_run++;
      if (dbg_rvalid !== 1'b1 || dbg_q.size() == 0) begin tests_failed++; $display("FAIL halt_dbg_rvalid: got %b want 1", dbg_rvalid); end
      else begin
         d = dbg_q.pop_front();
         if (dbg_rdata !== d) begin tests_failed++; $display("FAIL halt_dbg_data: got %h want %h", dbg_rdata, d); end
      end
      tests_run++; if ({halted, wb_gnt, id_gnt} !== 3'b100) begin tests_failed++; $display("FAIL halt_hold: got %b want 100", {halted, wb_gnt, id_gnt}); end
      step();
      sample();
      tests_run++; if ({halted, wb_gnt, id_gnt, rf_write_address} !== {3'b010, 5'd10}) begin tests_failed++; $display("FAIL resume_wb: got %h want %h", {halted, wb_gnt, id_gnt, rf_write_address}, {3'b010, 5'd10}); end
      step(); wb_req = 1'b0; id_q.push_back({32'h102, 32'h102});
      sample();
      tests_run++; if (id_gnt !== 1'b1) begin tests_failed++; $display("FAIL resume_id: got %b want 1", id_gnt); end
      step(); id_req = 1'b0;
      sample();
      tests_run++;
      if (id_rvalid !== 1'b1 || id_q.size() == 0) begin tests_failed++; $display("FAIL resume_rvalid: got %b want 1", id_rvalid); end
      else begin
         e = id_q.pop_front();
         if ({id_data_a, id_data_b} !== e) begin tests_failed++; $display("FAIL resume_data: got %h want %h", {id_data_a, id_data_b}, e); end
      end
   endtask

   task automatic test_idle();
      clear_inputs();
      for (int c = 0; c < 10; c++) begin
         step(); sample();
         tests_run++; if ({wb_gnt, id_gnt, dbg_gnt, id_rvalid, dbg_rvalid, rf_reg_write} !== 6'b0) begin tests_failed++; $display("FAIL idle_c%0d: got %b want 0", c, {wb_gnt, id_gnt, dbg_gnt, id_rvalid, dbg_rvalid, rf_reg_write}); end
      end
      tests_run++; if (id_q.size() + dbg_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: got %0d want 0", id_q.size() + dbg_q.size()); end
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_write_read();
      test_starvation();
      test_halt();
      test_idle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Single-port access arbiter for the 32x32 `registers` file, whose one port performs either a write (`reg_write=1`) or a registered read pair (`reg_write=0`) per clock. It shares that port between three requesters: pipeline write-back (write-only), decode (read pair), and the debug/loader port (read or write). It also provides a debug halt mode that freezes pipeline access. It sits between the pipeline stages and the register file.

## Interface
- `STARVE_LIMIT`, default 4: consecutive ungranted `dbg_req` cycles before debug is promoted to top priority (must be ≥1).
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_req`, `wb_addr`[5], `wb_data`[32]  in: write-back request.
- `wb_gnt`  out  1: write-back granted this cycle.
- `id_req`, `id_addr_a`[5], `id_addr_b`[5]  in: decode read-pair request.
- `id_gnt`  out  1: decode granted.
- `id_rvalid`  out  1: decode read data valid.
- `id_data_a`, `id_data_b`  out  32: decode read data.
- `dbg_req`, `dbg_we`, `dbg_addr`[5], `dbg_wdata`[32]  in: debug request (`dbg_we=1` write, `dbg_we=0` read of `dbg_addr`).
- `dbg_gnt`  out  1: debug granted.
- `dbg_rvalid`  out  1: debug read data valid.
- `dbg_rdata`  out  32: debug read data.
- `dbg_halt`  in  1: request halt of pipeline access.
- `halted`  out  1: halt is in effect.
- `rf_read_addr_a`, `rf_read_addr_b`, `rf_write_address`  out  5: register-file address drive.
- `rf_write_data`  out  32: register-file write data.
- `rf_reg_write`  out  1: register-file write enable.
- `rf_data_a`, `rf_data_b`  in  32: register-file registered read outputs.

## Operation
- **Request/grant handshake**
  - A requester holds `*_req` and its payload stable until it sees `*_gnt`.
  - `*_gnt` is combinational, asserted for exactly one cycle.
  - At most one `*_gnt` is asserted per cycle.
- **Arbitration per cycle**
  - Debug wins if starved (`starve_cnt == STARVE_LIMIT`).
  - Otherwise priority is wb > id > dbg.
  - In DRAIN and HALTED, only debug is eligible.
- **Register-file drive in the grant cycle**
  - wb: `rf_reg_write=1`, `rf_write_address=wb_addr`, `rf_write_data=wb_data`.
  - dbg write: `rf_reg_write=1`, `rf_write_address=dbg_addr`, `rf_write_data=dbg_wdata`.
  - id read: `rf_reg_write=0`, `rf_read_addr_a/b = id_addr_a/b`.
  - dbg read: `rf_reg_write=0`, both read addresses = `dbg_addr`.
  - No grant: `rf_reg_write=0`, addresses hold their last value. A read then occurs, but its data is never flagged valid.
- **Read return**
  - The `rd_owner` register (NONE/ID/DBG) is set at the clock edge ending a read-grant cycle, and cleared on the next edge unless another read is granted.
  - `id_rvalid = (rd_owner==ID)`, `dbg_rvalid = (rd_owner==DBG)`.
  - `id_data_a/b = rf_data_a/b` and `dbg_rdata = rf_data_a`, passed through combinationally.
- **Starvation counter**
  - Width: `$clog2(STARVE_LIMIT+1)` bits.
  - Increments, saturating at `STARVE_LIMIT`, on each cycle with `dbg_req=1` and `dbg_gnt=0`.
  - Clears to 0 on `dbg_gnt` or `dbg_req=0`.
- **Halt state machine**
  - RUN → DRAIN when `dbg_halt=1`.
  - DRAIN → HALTED when no grant issued to wb or id is still outstanding (i.e. `rd_owner != ID`). DRAIN → HALTED directly if nothing is outstanding.
  - HALTED → RUN when `dbg_halt=0`. DRAIN → RUN when `dbg_halt=0` (abort).
  - `halted = (state==HALTED)`, registered.
- **Reset (asynchronous, any time including mid-read)**
  - State RUN, `rd_owner` NONE, `starve_cnt` 0.
  - All `*_gnt`, `*_rvalid`, `halted`, and `rf_reg_write` are 0.
  - `rf` addresses and `rf_write_data` are 0.
  - An interrupted read is dropped, with no rvalid after reset release.

## Timing
- Grant in cycle N. The register-file write or read occurs at the end-of-N edge. Read data is valid with `*_rvalid` in cycle N+1 only.
- Read latency is 1 cycle from grant. Back-to-back reads are allowed, one per cycle at full throughput.
- A write granted in cycle N is visible to a read granted in N+1 or later. There is no bypass within the same cycle, because they cannot coexist.
- `halted` rises 1 cycle after the DRAIN exit condition is met, and falls 1 cycle after `dbg_halt` deasserts.
- Worst-case debug wait in RUN is `STARVE_LIMIT` cycles, after which it is granted.

## Test plan
- **Reset:** assert `reset_n=0` in the cycle after an id grant → no `id_rvalid`; all outputs 0. After release, `id_req` (1,0) is granted in the first cycle, then `id_data_a=3`, `id_data_b=2`.
- **Write/read ordering:** `wb_req` r5=0xDEADBEEF and `id_req` (5,1) raised in the same cycle N → `wb_gnt` at N, `id_gnt` at N+1, `id_rvalid` at N+2 with `data_a=0xDEADBEEF`, `data_b=3`.
- **Starvation:** hold `wb_req` and `id_req` continuously, plus `dbg_req` read r0 → `dbg_gnt` at exactly the 5th cycle of `dbg_req` (after 4 waits), `dbg_rvalid` next cycle with `dbg_rdata=2`, counter back to 0.
- **Halt:** raise `dbg_halt` in the cycle after an id grant → `id_rvalid` is still delivered and `halted=1` one cycle later. `wb_req` and `id_req` are never granted while halted. Debug write r7=0x12 then read r7 → 0x12. Drop `dbg_halt` → `halted=0` next cycle, then pending `wb_req` granted.
- **Idle:** no requests for 10 cycles → `rf_reg_write=0`; no gnt and no rvalid ever asserted.
